// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider, configurable frame
// (data bits, parity, stop bits) and a small input FIFO behind valid/ready.
// Single clock domain; the baud rate is a clock-enable count, not a divided clock.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 4,
    parameter int PARITY     = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_BITS-1:0]                in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    output logic                                tx,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int CNT_W  = $clog2(DATA_BITS);

    localparam bit PARAMS_OK = (DATA_BITS >= 5) && (DATA_BITS <= 9) &&
                               (CLK_DIV >= 2) &&
                               (PARITY >= 0) && (PARITY <= 2) &&
                               ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                               (FIFO_DEPTH >= 2) &&
                               ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_d;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    // Transmit FSM state
    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_d;
    logic                 busy_d;
    logic                 baud_end;

    assign in_ready = (level != LVL_W'(FIFO_DEPTH));
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];
    assign baud_end = (baud_q == BAUD_W'(CLK_DIV - 1));

    // Trap illegal parameter sets as soon as the clock runs in simulation
    always_ff @(posedge clk) begin
        assert (PARAMS_OK) else $error("uart_tx_fifo: illegal parameter set");
    end

    // Level bookkeeping: simultaneous push and pop leave the count unchanged
    always_comb begin
        level_d = level;
        case ({push, pop})
            2'b10:   level_d = level + 1'b1;
            2'b01:   level_d = level - 1'b1;
            default: level_d = level;
        endcase
    end

    // FIFO pointers and level register
    always_ff @(posedge clk) begin
        // NOTE: every clocked register uses non-blocking assignment so all
        // flops update together from pre-edge values, regardless of order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_d;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; empty slots are never read
        // because the level and pointers are reset, so clearing it buys nothing.
        if (push) mem[wr_ptr] <= in_data;
    end

    // Next-state, baud/bit counting, pop decision and next tx value
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        tx_d    = 1'b1;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (level != '0) pop = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == CNT_W'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == CNT_W'(STOP_BITS - 1)) begin
                        if (level != '0) pop = 1'b1;
                        else             state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop loads the next word and restarts the bit timing at a start bit
        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~(^head) : ^head;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) | (level_d != '0);
    end

    // FSM registers; tx and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx      <= tx_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: four frame formats side by side,
// a table of single-frame vectors plus hand-written FIFO, back-to-back
// and mid-frame reset sequences.
module tb_uart_tx_fifo;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] v;
    logic [7:0] d0, d1, d2;
    logic [6:0] d7;
    logic [3:0] rdy_v, tx_v, busy_v;
    logic [2:0] lvl [4];

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1, 8E1, 8O1 and 7N2, all CLK_DIV=4 and FIFO_DEPTH=4
    uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v[0]), .in_ready(rdy_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .level(lvl[0]));
    uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v[1]), .in_ready(rdy_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .level(lvl[1]));
    uart_tx_fifo #(.DATA_BITS(8), .CLK_DIV(DIV), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v[2]), .in_ready(rdy_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .level(lvl[2]));
    uart_tx_fifo #(.DATA_BITS(7), .CLK_DIV(DIV), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .in_data(d7), .in_valid(v[3]), .in_ready(rdy_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .level(lvl[3]));

    always #5 clk = ~clk;

    // One frame vector: instance, word, frame length in bits, wire bits (bit 0 first)
    typedef struct {
        int unsigned inst;
        logic [7:0]  data;
        int unsigned nbits;
        logic [11:0] bits;
    } vec_t;

    vec_t       vecs [10];
    logic [7:0] sf_data [3];
    logic [11:0] sf_bits [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input int inst, input logic valid, input logic [7:0] data);
        case (inst)
            0: begin v[0] = valid; d0 = data; end
            1: begin v[1] = valid; d1 = data; end
            2: begin v[2] = valid; d2 = data; end
            default: begin v[3] = valid; d7 = data[6:0]; end
        endcase
    endtask

    // Push one word into an idle instance and check every cycle of its frame
    task automatic run_vec(input vec_t vc, input int idx);
        int len;
        len = int'(vc.nbits) * DIV;
        @(negedge clk); drive(int'(vc.inst), 1'b1, vc.data);
        @(negedge clk); drive(int'(vc.inst), 1'b0, 8'h00);
        check($sformatf("v%0d_level_before_pop", idx), 32'(lvl[vc.inst]), 32'd1);
        check($sformatf("v%0d_tx_before_pop", idx), 32'(tx_v[vc.inst]), 32'd1);
        check($sformatf("v%0d_busy_after_push", idx), 32'(busy_v[vc.inst]), 32'd1);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == 0) check($sformatf("v%0d_level_after_pop", idx), 32'(lvl[vc.inst]), 32'd0);
            check($sformatf("v%0d_tx_c%0d", idx, c), 32'(tx_v[vc.inst]), 32'(vc.bits[c / DIV]));
            check($sformatf("v%0d_busy_c%0d", idx, c), 32'(busy_v[vc.inst]), 32'd1);
        end
        @(negedge clk);
        check($sformatf("v%0d_tx_idle", idx), 32'(tx_v[vc.inst]), 32'd1);
        check($sformatf("v%0d_busy_idle", idx), 32'(busy_v[vc.inst]), 32'd0);
    endtask

    // Push n words on consecutive cycles and check the contiguous stream of
    // frames given in sf_bits (fb bits per frame)
    task automatic run_stream(input string tag, input int inst, input int n, input int fb);
        int total;
        int k;
        total = n * fb * DIV;
        @(negedge clk); drive(inst, 1'b1, sf_data[0]);
        @(negedge clk); drive(inst, 1'b1, sf_data[1]);
        for (int idx = 0; idx < total; idx++) begin
            @(negedge clk);
            k = idx + 2;
            if (k < n)       drive(inst, 1'b1, sf_data[k]);
            else if (k == n) drive(inst, 1'b0, 8'h00);
            check($sformatf("%s_tx_c%0d", tag, idx), 32'(tx_v[inst]),
                  32'(sf_bits[idx / (fb * DIV)][(idx / DIV) % fb]));
            check($sformatf("%s_busy_c%0d", tag, idx), 32'(busy_v[inst]), 32'd1);
        end
        @(negedge clk);
        check($sformatf("%s_tx_idle", tag), 32'(tx_v[inst]), 32'd1);
        check($sformatf("%s_busy_idle", tag), 32'(busy_v[inst]), 32'd0);
    endtask

    // Hard stop in case a sequence loses sync with the DUT
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int found;
        int low_cycles;
        logic [7:0] fill [8];

        // Hand-computed frames: bit 0 is the start bit, then data LSB first,
        // parity (if any), stop bit(s)
        vecs[0] = '{inst: 0, data: 8'h41, nbits: 10, bits: 12'h282};
        vecs[1] = '{inst: 0, data: 8'hA5, nbits: 10, bits: 12'h34A};
        vecs[2] = '{inst: 0, data: 8'h00, nbits: 10, bits: 12'h200};
        vecs[3] = '{inst: 0, data: 8'hFF, nbits: 10, bits: 12'h3FE};
        vecs[4] = '{inst: 1, data: 8'h03, nbits: 11, bits: 12'h406};  // even parity 0
        vecs[5] = '{inst: 2, data: 8'h03, nbits: 11, bits: 12'h606};  // odd parity 1
        vecs[6] = '{inst: 1, data: 8'h07, nbits: 11, bits: 12'h60E};  // even parity 1
        vecs[7] = '{inst: 2, data: 8'h07, nbits: 11, bits: 12'h40E};  // odd parity 0
        vecs[8] = '{inst: 3, data: 8'h7F, nbits: 10, bits: 12'h3FE};  // 7N2, 8 stop cycles
        vecs[9] = '{inst: 3, data: 8'h55, nbits: 10, bits: 12'h3AA};

        v = 4'h0; d0 = '0; d1 = '0; d2 = '0; d7 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_tx%0d", i), 32'(tx_v[i]), 32'd1);
            check($sformatf("rst_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("rst_level%0d", i), 32'(lvl[i]), 32'd0);
            check($sformatf("rst_ready%0d", i), 32'(rdy_v[i]), 32'd1);
        end
        rst = 1'b0;

        // Single frames, every format
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Three queued words go out back to back, in order, no idle gap
        sf_data[0] = 8'h41; sf_bits[0] = 12'h282;
        sf_data[1] = 8'hC3; sf_bits[1] = 12'h386;
        sf_data[2] = 8'h5A; sf_bits[2] = 12'h2B4;
        run_stream("b2b3", 0, 3, 10);

        // Two stop bits followed directly by the next start bit
        sf_data[0] = 8'h7F; sf_bits[0] = 12'h3FE;
        sf_data[1] = 8'h00; sf_bits[1] = 12'h300;
        run_stream("b2b7n2", 3, 2, 10);

        // Hold in_valid from idle: five words accepted, then the FIFO is full
        for (int i = 0; i < 8; i++) fill[i] = 8'h10 + 8'(i);
        acc = 0;
        @(negedge clk); drive(0, 1'b1, fill[0]);
        for (int cyc = 0; cyc < 8; cyc++) begin
            found = int'(rdy_v[0]);
            @(negedge clk);
            if (found != 0) begin
                acc++;
                drive(0, 1'b1, fill[acc]);
            end
        end
        check("fill_accepted", 32'(acc), 32'd5);
        check("fill_ready_low", 32'(rdy_v[0]), 32'd0);
        check("fill_level", 32'(lvl[0]), 32'd4);

        // The next pop opens in_ready for exactly one cycle
        found = 0;
        for (int cyc = 0; cyc < 60 && found == 0; cyc++) begin
            if (rdy_v[0]) found = 1;
            else @(negedge clk);
        end
        check("pop_ready_seen", 32'(found), 32'd1);
        check("pop_level", 32'(lvl[0]), 32'd3);
        @(negedge clk); drive(0, 1'b0, 8'h00);
        check("pop_ready_one_cycle", 32'(rdy_v[0]), 32'd0);
        check("pop_refill_level", 32'(lvl[0]), 32'd4);

        // Reset in the middle of a data bit with words still queued
        repeat (8) @(negedge clk);
        check("midframe_busy", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx_v[0]), 32'd1);
        check("midrst_level", 32'(lvl[0]), 32'd0);
        check("midrst_busy", 32'(busy_v[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(rdy_v[0]), 32'd1);
        low_cycles = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) low_cycles++;
        end
        check("midrst_no_frames", 32'(low_cycles), 32'd0);

        // A fresh push after reset transmits normally
        run_vec(vecs[1], 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
